serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
Parallel-in, serial-out word transmitter. It is the sending end for the team's flip-flop/shift-register capture path. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single line as a framed serial stream: one start bit (0), the data bits LSB first, then one stop bit (1). Each bit is held for DIV clock cycles. A global enable freezes the block, matching the EN semantics of the storage cells.

Parameters:
WIDTH, 8, data bits per frame (>=1)
DIV, 4, clock cycles each serial bit is held (>=1)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
EN  input  1  global enable; 0 freezes all state and counters
data_in  input  WIDTH  word to transmit; sampled only on accept
load_valid  input  1  producer has a word on data_in
load_ready  output  1  block can accept a word (IDLE only)
tx  output  1  serial line; idles high
busy  output  1  frame in progress (START, DATA or STOP)
done  output  1  one-cycle pulse when a stop bit completes

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous, regardless of clock or EN):
  - Outputs: tx=1, load_ready=1, busy=0, done=0.
  - Internal: state=IDLE, shift register=0, bit/divider counters=0.
- States: IDLE, START, DATA, STOP.
- Accept: at a rising edge with EN=1, state=IDLE and load_valid=1:
  - Latch data_in into the shift register; go to START.
  - From that edge: tx=0, busy=1, load_ready=0, divider=0.
- Divider: counts 0..DIV-1 while EN=1 in START/DATA/STOP. The bit advances when the divider reaches DIV-1 at a rising edge; the divider then wraps to 0.
- Advance in START -> DATA: tx=shift[0], bit counter=0.
- Advance in DATA:
  - If bit counter < WIDTH-1: shift right, tx=next LSB, increment bit counter.
  - Otherwise go to STOP with tx=1.
- Advance in STOP -> IDLE: tx=1, busy=0, load_ready=1, done=1.
- done: high for exactly one cycle and cleared at the next rising edge, even if EN=0.
- Timing, with accept at edge k:
  - Start bit occupies cycles k..k+DIV-1.
  - Data bit i begins at edge k+DIV*(1+i).
  - Stop bit begins at k+DIV*(WIDTH+1).
  - IDLE/done is reached at edge k+DIV*(WIDTH+2).
- Back-to-back frames: the next accept is possible at the edge after IDLE is entered, so the minimum frame period is DIV*(WIDTH+2)+1 cycles. tx stays 1 in the gap.
- EN=0: state, counters, shift register and tx hold their values. Frame timing stretches by exactly the number of disabled cycles. No accept occurs.
- load_valid while not IDLE is ignored, with no queuing. data_in changes after accept have no effect.
- load_valid and EN rising together in IDLE: accept at that edge.
- Reset mid-frame aborts the frame: tx returns to 1 immediately and no done pulse is produced.
- DIV=1: one cycle per bit, with the divider held at 0.
- WIDTH=1: a single DATA bit.
- Counter widths:
  - Divider: $clog2(DIV), minimum 1 bit.
  - Bit counter: $clog2(WIDTH), minimum 1 bit.
  - No overflow is permitted beyond these bounds.

Test Plan:
1. Reset, then idle:
   - Stimulus: reset=0 for 3 cycles, then release; EN=1, load_valid=0 for 20 cycles.
   - Required: tx=1, load_ready=1, busy=0, done=0 throughout.
2. Basic frame (WIDTH=8, DIV=4):
   - Stimulus: accept data_in=8'hA5 at edge k.
   - Required tx sequence, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
   - Required: done=1 only in cycle k+40; busy=1 for cycles k..k+39.
3. Ignored load, then back-to-back:
   - Stimulus: present 8'hFF at k+10 while busy. Then hold load_valid=1 with 8'h3C after done.
   - Required: the first frame is unchanged. The second accept happens at k+41 and sends 0 | 0,0,1,1,1,1,0,0 | 1.
4. Enable freeze:
   - Stimulus: send 8'h01, then drop EN for 7 cycles during data bit 3.
   - Required: tx and busy hold for those cycles; done occurs 7 cycles later than in scenario 2 timing.
5. Reset mid-frame:
   - Stimulus: assert reset=0 asynchronously between edges during data bit 5 of 8'h55.
   - Required: tx=1, busy=0, load_ready=1 before the next edge; no done pulse. A fresh accept of 8'h0F afterwards transmits a correct frame.
6. DIV=1, WIDTH=4 instance:
   - Stimulus: accept 4'b1001.
   - Required: tx per cycle 0,1,0,0,1,1; done at k+6.

Source files
------------

// File: rtl/serial_word_tx_if.sv
// -----------------------------------------------------------------------------
// serial_word_tx_if
//   Handshake and serial-line bundle for serial_word_tx.
//
//   data_in     word offered by the producer (WIDTH bits)
//   load_valid  producer has a word on data_in
//   load_ready  transmitter is idle and will accept a word
//   tx          serial line, idles high
//   busy        frame in progress
//   done        one-cycle pulse when a stop bit completes
//
//   master: producer / observer side
//   slave : transmitter side
// -----------------------------------------------------------------------------
interface serial_word_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             tx;
   logic             busy;
   logic             done;

   modport master (
      output data_in,
      output load_valid,
      input  load_ready,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  data_in,
      input  load_valid,
      output load_ready,
      output tx,
      output busy,
      output done
   );
endinterface

// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//   Parallel-in, serial-out word transmitter. A WIDTH-bit word accepted over a
//   valid/ready handshake is sent as: start bit (0), data bits LSB first,
//   stop bit (1). Every bit is held for DIV clock cycles. EN=0 freezes all
//   state, counters and the line; the pending done pulse still clears.
//
//   Ports
//     clock  rising-edge clock
//     reset  asynchronous active-low reset
//     EN     global enable
//     bus    serial_word_tx_if.slave: data_in, load_valid (in);
//            load_ready, tx, busy, done (out, all registered)
// -----------------------------------------------------------------------------
module serial_word_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              EN,
   serial_word_tx_if.slave   bus
);

   localparam int DIV_W = (DIV   > 1) ? $clog2(DIV)   : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   shift_reg;
   logic [WIDTH-1:0]   shift_next;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic               bit_end;

   // With DIV=1 the divider sits at 0 and every enabled edge ends a bit.
   assign bit_end    = (div_cnt == DIV_MAX);
   assign shift_next = shift_reg >> 1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         shift_reg      <= '0;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         bus.tx         <= 1'b1;
         bus.load_ready <= 1'b1;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         // done is a strict one-cycle pulse, independent of EN.
         bus.done <= 1'b0;

         if (EN) begin
            case (state)
               IDLE: begin
                  if (bus.load_valid) begin
                     shift_reg      <= bus.data_in;
                     state          <= START;
                     div_cnt        <= '0;
                     bus.tx         <= 1'b0;
                     bus.busy       <= 1'b1;
                     bus.load_ready <= 1'b0;
                  end
               end

               START: begin
                  if (bit_end) begin
                     div_cnt <= '0;
                     bit_cnt <= '0;
                     state   <= DATA;
                     bus.tx  <= shift_reg[0];
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end

               DATA: begin
                  if (bit_end) begin
                     div_cnt <= '0;
                     if (bit_cnt < BIT_MAX) begin
                        shift_reg <= shift_next;
                        bus.tx    <= shift_next[0];
                        bit_cnt   <= bit_cnt + 1'b1;
                     end else begin
                        state  <= STOP;
                        bus.tx <= 1'b1;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end

               STOP: begin
                  if (bit_end) begin
                     div_cnt        <= '0;
                     state          <= IDLE;
                     bus.tx         <= 1'b1;
                     bus.busy       <= 1'b0;
                     bus.load_ready <= 1'b1;
                     bus.done       <= 1'b1;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

   logic clock;
   logic reset;
   logic EN;
   int   checks;
   int   failures;

   serial_word_tx_if #(.WIDTH(8)) bus_a ();
   serial_word_tx_if #(.WIDTH(4)) bus_b ();

   serial_word_tx #(.WIDTH(8), .DIV(4)) dut_a (
      .clock (clock),
      .reset (reset),
      .EN    (EN),
      .bus   (bus_a)
   );

   serial_word_tx #(.WIDTH(4), .DIV(1)) dut_b (
      .clock (clock),
      .reset (reset),
      .EN    (EN),
      .bus   (bus_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b0;
      EN    = 1'b1;
      bus_a.load_valid = 1'b0;
      bus_a.data_in    = '0;
      bus_b.load_valid = 1'b0;
      bus_b.data_in    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if (bus_a.tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus_a.tx); end
      checks++; if (bus_a.load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_a.load_ready); end
      checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
      checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
      reset = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         checks++;
         if ({bus_a.tx, bus_a.load_ready, bus_a.busy, bus_a.done} !== 4'b1100) begin
            failures++;
            $display("FAIL idle n=%0d tx/ready/busy/done got=%b exp=1100", n,
                     {bus_a.tx, bus_a.load_ready, bus_a.busy, bus_a.done});
         end
      end
   endtask

   task automatic test_basic_frame();
      logic [9:0] exp_bits;
      logic       exp_tx;
      exp_bits = 10'b1_10100101_0;
      @(negedge clock);
      bus_a.data_in    = 8'hA5;
      bus_a.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_a.load_valid = 1'b0;
      bus_a.data_in    = 8'h00;
      for (int n = 0; n <= 41; n++) begin
         @(negedge clock);
         exp_tx = (n < 40) ? exp_bits[n/4] : 1'b1;
         checks++;
         if (bus_a.tx !== exp_tx) begin
            failures++; $display("FAIL basic_tx n=%0d got=%b exp=%b", n, bus_a.tx, exp_tx);
         end
         checks++;
         if ({bus_a.busy, bus_a.done, bus_a.load_ready} !== {n < 40, n == 40, n >= 40}) begin
            failures++;
            $display("FAIL basic_ctrl n=%0d busy/done/ready got=%b exp=%b", n,
                     {bus_a.busy, bus_a.done, bus_a.load_ready}, {n < 40, n == 40, n >= 40});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp1;
      logic [9:0] exp2;
      logic       exp_tx;
      exp1 = 10'b1_10100101_0;
      exp2 = 10'b1_00111100_0;
      @(negedge clock);
      bus_a.data_in    = 8'hA5;
      bus_a.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_a.load_valid = 1'b0;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clock);
         exp_tx = (n < 40) ? exp1[n/4] : 1'b1;
         checks++;
         if (bus_a.tx !== exp_tx) begin
            failures++; $display("FAIL b2b_first_tx n=%0d got=%b exp=%b", n, bus_a.tx, exp_tx);
         end
         checks++;
         if ({bus_a.busy, bus_a.done} !== {n < 40, n == 40}) begin
            failures++;
            $display("FAIL b2b_first_ctrl n=%0d busy/done got=%b exp=%b", n,
                     {bus_a.busy, bus_a.done}, {n < 40, n == 40});
         end
         if (n == 9) begin
            bus_a.data_in    = 8'hFF;
            bus_a.load_valid = 1'b1;
         end
         if (n == 10) bus_a.load_valid = 1'b0;
         if (n == 40) begin
            bus_a.data_in    = 8'h3C;
            bus_a.load_valid = 1'b1;
         end
      end
      for (int n = 0; n <= 41; n++) begin
         @(negedge clock);
         if (n == 0) bus_a.load_valid = 1'b0;
         exp_tx = (n < 40) ? exp2[n/4] : 1'b1;
         checks++;
         if (bus_a.tx !== exp_tx) begin
            failures++; $display("FAIL b2b_second_tx n=%0d got=%b exp=%b", n, bus_a.tx, exp_tx);
         end
         checks++;
         if ({bus_a.busy, bus_a.done} !== {n < 40, n == 40}) begin
            failures++;
            $display("FAIL b2b_second_ctrl n=%0d busy/done got=%b exp=%b", n,
                     {bus_a.busy, bus_a.done}, {n < 40, n == 40});
         end
      end
   endtask

   task automatic test_enable_freeze();
      logic [9:0] exp_bits;
      logic       exp_tx;
      int         m;
      int         w;
      exp_bits = 10'b1_00000001_0;
      @(negedge clock);
      bus_a.data_in    = 8'h01;
      bus_a.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_a.load_valid = 1'b0;
      for (int n = 0; n <= 48; n++) begin
         @(negedge clock);
         // Edges k+18..k+24 are disabled, so timing slips by 7 cycles.
         m = (n <= 17) ? n : ((n <= 24) ? 17 : n - 7);
         exp_tx = (m < 40) ? exp_bits[m/4] : 1'b1;
         checks++;
         if (bus_a.tx !== exp_tx) begin
            failures++; $display("FAIL freeze_tx n=%0d got=%b exp=%b", n, bus_a.tx, exp_tx);
         end
         checks++;
         if ({bus_a.busy, bus_a.done} !== {m < 40, m == 40}) begin
            failures++;
            $display("FAIL freeze_ctrl n=%0d busy/done got=%b exp=%b", n,
                     {bus_a.busy, bus_a.done}, {m < 40, m == 40});
         end
         if (n == 17) EN = 1'b0;
         if (n == 24) EN = 1'b1;
      end
      // No accept while disabled; accept on the edge where EN returns.
      @(negedge clock);
      EN = 1'b0;
      bus_a.data_in    = 8'h81;
      bus_a.load_valid = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if ({bus_a.busy, bus_a.load_ready, bus_a.tx} !== 3'b011) begin
            failures++;
            $display("FAIL en_low_no_accept busy/ready/tx got=%b exp=011",
                     {bus_a.busy, bus_a.load_ready, bus_a.tx});
         end
      end
      EN = 1'b1;
      @(negedge clock);
      bus_a.load_valid = 1'b0;
      checks++;
      if ({bus_a.busy, bus_a.load_ready, bus_a.tx} !== 3'b100) begin
         failures++;
         $display("FAIL en_rise_accept busy/ready/tx got=%b exp=100",
                  {bus_a.busy, bus_a.load_ready, bus_a.tx});
      end
      w = 0;
      while (bus_a.done !== 1'b1 && w < 60) begin
         @(negedge clock);
         w++;
      end
      checks++;
      if (w != 40) begin
         failures++; $display("FAIL en_rise_done_cycles got=%0d exp=40", w);
      end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] exp_bits;
      logic       exp_tx;
      int         done_seen;
      @(negedge clock);
      bus_a.data_in    = 8'h55;
      bus_a.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_a.load_valid = 1'b0;
      repeat (26) @(negedge clock);
      checks++;
      if ({bus_a.tx, bus_a.busy} !== 2'b01) begin
         failures++; $display("FAIL midframe_pre tx/busy got=%b exp=01", {bus_a.tx, bus_a.busy});
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus_a.tx, bus_a.busy, bus_a.load_ready, bus_a.done} !== 4'b1010) begin
         failures++;
         $display("FAIL midframe_abort tx/busy/ready/done got=%b exp=1010",
                  {bus_a.tx, bus_a.busy, bus_a.load_ready, bus_a.done});
      end
      @(negedge clock);
      reset = 1'b1;
      done_seen = 0;
      repeat (45) begin
         @(negedge clock);
         if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         failures++; $display("FAIL midframe_no_done got=%0d exp=0", done_seen);
      end
      exp_bits = 10'b1_00001111_0;
      bus_a.data_in    = 8'h0F;
      bus_a.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_a.load_valid = 1'b0;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clock);
         exp_tx = (n < 40) ? exp_bits[n/4] : 1'b1;
         checks++;
         if (bus_a.tx !== exp_tx) begin
            failures++; $display("FAIL after_reset_tx n=%0d got=%b exp=%b", n, bus_a.tx, exp_tx);
         end
         checks++;
         if ({bus_a.busy, bus_a.done} !== {n < 40, n == 40}) begin
            failures++;
            $display("FAIL after_reset_ctrl n=%0d busy/done got=%b exp=%b", n,
                     {bus_a.busy, bus_a.done}, {n < 40, n == 40});
         end
      end
   endtask

   task automatic test_div1_width4();
      logic [5:0] exp_bits;
      logic       exp_tx;
      exp_bits = 6'b1_1001_0;
      @(negedge clock);
      bus_b.data_in    = 4'b1001;
      bus_b.load_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_b.load_valid = 1'b0;
      for (int n = 0; n <= 7; n++) begin
         @(negedge clock);
         exp_tx = (n < 6) ? exp_bits[n] : 1'b1;
         checks++;
         if (bus_b.tx !== exp_tx) begin
            failures++; $display("FAIL div1_tx n=%0d got=%b exp=%b", n, bus_b.tx, exp_tx);
         end
         checks++;
         if ({bus_b.busy, bus_b.done} !== {n < 6, n == 6}) begin
            failures++;
            $display("FAIL div1_ctrl n=%0d busy/done got=%b exp=%b", n,
                     {bus_b.busy, bus_b.done}, {n < 6, n == 6});
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_enable_freeze();
      test_reset_midframe();
      test_div1_width4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
